// File: rtl/counter_multimode_pkg.sv
// Shared mode encodings for the multimode counter and its prescaler.
package counter_multimode_pkg;

   typedef enum logic [1:0] {
      MODE_SAT     = 2'b00,
      MODE_WRAP    = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_SAT_ALT = 2'b11
   } mode_e;

   function automatic logic is_wrap(input logic [1:0] m);
      return mode_e'(m) == MODE_WRAP;
   endfunction

endpackage

// File: rtl/counter_multimode_tick_prescaler.sv
// Divides enabled cycles by (prescale+1); tick is combinational on the terminal count.
// No backpressure: en freezes the count, restart forces it back to zero.
module tick_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      restart,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

   // A prescale lowered below cnt_q is never matched until cnt_q rolls over.
   assign tick = en & (cnt_q == prescale);

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/counter_multimode.sv
// Up/down counter with prescaler and programmable limit: saturate, wrap or one-shot.
// out/wrap_pulse/done update on the edge where a step occurs; no backpressure.
module counter_multimode
   import counter_multimode_pkg::*;
#(
   parameter int DATA_WIDTH     = 10,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      load,
   input  logic [DATA_WIDTH-1:0]     load_val,
   input  logic                      up_dn,
   input  logic [1:0]                mode,
   input  logic [DATA_WIDTH-1:0]     max_val,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [DATA_WIDTH-1:0]     out,
   output logic                      at_limit,
   output logic                      wrap_pulse,
   output logic                      done
);

   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  wrap_q, wrap_d;
   logic                  done_q, done_d;
   logic                  frozen;
   logic                  tick;
   logic                  step;

   // A finished one-shot stalls both the counter and the prescaler.
   assign frozen = (mode_e'(mode) == MODE_ONESHOT) & done_q;

   tick_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (en & ~frozen),
      .restart (clr | load),
      .prescale(prescale),
      .tick    (tick)
   );

   assign step = tick & ~clr & ~load;

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      done_d = done_q;
      if (clr) begin
         out_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         out_d  = load_val;
         done_d = 1'b0;
      end else if (step) begin
         if (up_dn) begin
            if (is_wrap(mode)) begin
               if (out_q >= max_val) begin
                  out_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  out_d = out_q + 1'b1;
               end
            end else begin
               out_d = (out_q < max_val) ? out_q + 1'b1 : max_val;
            end
         end else begin
            if (out_q == '0) begin
               out_d  = is_wrap(mode) ? max_val : '0;
               wrap_d = is_wrap(mode);
            end else begin
               out_d = out_q - 1'b1;
            end
         end
         if (mode_e'(mode) == MODE_ONESHOT &&
             (up_dn ? (out_d == max_val) : (out_d == '0))) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         done_q <= done_d;
      end
   end

   assign out        = out_q;
   assign wrap_pulse = wrap_q;
   assign done       = done_q;
   assign at_limit   = up_dn ? (out_q >= max_val) : (out_q == '0);

endmodule

// File: tb/tb_counter_multimode.sv
// Table-driven bench for counter_multimode with an expected-value queue.
module tb_counter_multimode;

   localparam logic [1:0] M_SAT = 2'b00, M_WRAP = 2'b01, M_ONE = 2'b10, M_SAT2 = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, clr, load, up_dn;
   logic [9:0] load_val, max_val;
   logic [1:0] mode;
   logic [7:0] prescale;
   logic [9:0] out;
   logic       at_limit, wrap_pulse, done;

   counter_multimode #(.DATA_WIDTH(10), .PRESCALE_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .up_dn(up_dn), .mode(mode), .max_val(max_val), .prescale(prescale),
      .out(out), .at_limit(at_limit), .wrap_pulse(wrap_pulse), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, clr, load;
      logic [9:0] load_val;
      logic       up_dn;
      logic [1:0] mode;
      logic [9:0] max_val;
      logic [7:0] prescale;
      logic [9:0] e_out;
      logic       e_lim, e_wrap, e_done;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [1:0] c_mode;
   logic       c_up;
   logic [9:0] c_max;
   logic [7:0] c_ps;

   task automatic cfg(input logic [1:0] m, input logic u, input logic [9:0] mx, input logic [7:0] ps);
      c_mode = m; c_up = u; c_max = mx; c_ps = ps;
   endtask

   function automatic vec_t mk(input logic e, input logic c, input logic l, input logic [9:0] lv,
                               input logic [9:0] o, input logic lim, input logic w, input logic d);
      vec_t v;
      v.en = e; v.clr = c; v.load = l; v.load_val = lv;
      v.up_dn = c_up; v.mode = c_mode; v.max_val = c_max; v.prescale = c_ps;
      v.e_out = o; v.e_lim = lim; v.e_wrap = w; v.e_done = d;
      return v;
   endfunction

   task automatic add(input logic e, input logic c, input logic l, input logic [9:0] lv,
                      input logic [9:0] o, input logic lim, input logic w, input logic d);
      tbl.push_back(mk(e, c, l, lv, o, lim, w, d));
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      en = v.en; clr = v.clr; load = v.load; load_val = v.load_val;
      up_dn = v.up_dn; mode = v.mode; max_val = v.max_val; prescale = v.prescale;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, " out"},      int'(out),        int'(e.e_out));
      check({tag, " at_limit"}, int'(at_limit),   int'(e.e_lim));
      check({tag, " wrap"},     int'(wrap_pulse), int'(e.e_wrap));
      check({tag, " done"},     int'(done),       int'(e.e_done));
   endtask

   int o;
   int wrap_seq[15] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
   int down_seq[7]  = '{5, 4, 3, 2, 1, 0, 5};

   initial begin
      // Saturate up, max 8, prescale 0
      cfg(M_SAT, 1'b1, 10'd8, 8'd0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         o = (i > 8) ? 8 : i;
         add(1, 0, 0, 0, 10'(o), o == 8, 0, 0);
      end
      // en=0 freezes the prescaler
      cfg(M_SAT, 1'b1, 10'd8, 8'd1);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 2, 0, 0, 0);
      // Wrap up, max 3, prescale 2
      cfg(M_WRAP, 1'b1, 10'd3, 8'd2);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++)
         add(1, 0, 0, 0, 10'(wrap_seq[i]), wrap_seq[i] == 3, i == 11, 0);
      // Wrap down from load 0, max 5
      cfg(M_WRAP, 1'b0, 10'd5, 8'd0);
      add(1, 0, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++)
         add(1, 0, 0, 0, 10'(down_seq[i]), down_seq[i] == 0, down_seq[i] == 5, 0);
      // One-shot down from load 4, held, then clr
      cfg(M_ONE, 1'b0, 10'd8, 8'd0);
      add(1, 0, 1, 4, 4, 0, 0, 0);
      add(1, 0, 0, 0, 3, 0, 0, 0);
      add(1, 0, 0, 0, 2, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, 1, 0, 0);
      // One-shot up to max 3, then hold
      cfg(M_ONE, 1'b1, 10'd3, 8'd0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 2, 0, 0, 0);
      add(1, 0, 0, 0, 3, 1, 0, 1);
      add(1, 0, 0, 0, 3, 1, 0, 1);
      add(1, 0, 0, 0, 3, 1, 0, 1);
      // Priority clr > load > step; load above max then clamp
      cfg(M_SAT, 1'b1, 10'd8, 8'd0);
      add(1, 0, 1, 6, 6, 0, 0, 0);
      add(1, 1, 1, 7, 0, 0, 0, 0);
      add(1, 0, 1, 900, 900, 1, 0, 0);
      add(1, 0, 0, 0, 8, 1, 0, 0);
      // max_val = 0
      cfg(M_WRAP, 1'b1, 10'd0, 8'd0);
      add(1, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 1, 1, 0);
      cfg(M_SAT, 1'b1, 10'd0, 8'd0);
      add(1, 0, 0, 0, 0, 1, 0, 0);
      // Mode 11 behaves as saturate
      cfg(M_SAT2, 1'b1, 10'd2, 8'd0);
      add(1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 2, 1, 0, 0);
      add(1, 0, 0, 0, 2, 1, 0, 0);

      rst = 1'b1; en = 0; clr = 0; load = 0; load_val = 0;
      up_dn = 1; mode = M_SAT; max_val = 10'd8; prescale = 0;
      #12;
      check("reset out",  int'(out),        0);
      check("reset wrap", int'(wrap_pulse), 0);
      check("reset done", int'(done),       0);
      check("reset lim",  int'(at_limit),   0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

      // Async reset mid-count with out=5 and done set
      cfg(M_ONE, 1'b1, 10'd5, 8'd0);
      apply(mk(1, 0, 1, 4, 4, 0, 0, 0), "rs0");
      apply(mk(1, 0, 0, 0, 5, 1, 0, 1), "rs1");
      #2 rst = 1'b1;
      #1;
      check("async rst out",  int'(out),  0);
      check("async rst done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      // Async reset while wrap_pulse is high
      cfg(M_WRAP, 1'b1, 10'd0, 8'd0);
      apply(mk(1, 1, 0, 0, 0, 1, 0, 0), "rw0");
      apply(mk(1, 0, 0, 0, 0, 1, 1, 0), "rw1");
      #2 rst = 1'b1;
      #1;
      check("async rst wrap", int'(wrap_pulse), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
